// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// A queue entry carries the fetched word and its predecoded side information.
package fetch_pkg;

    localparam logic [31:0] PC_STEP     = 32'd4;
    localparam logic [31:0] PC_READ_OFS = 32'd8;
    localparam logic [3:0]  FP_CLASS    = 4'hC;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        is_fp;
    } fetch_entry_t;

    // Predecode at push time so decode never sees a path from imem_rd.
    function automatic fetch_entry_t make_entry(input logic [31:0] word, input logic [31:0] pc);
        fetch_entry_t e;
        e.word  = word;
        e.pc    = pc;
        e.pc8   = pc + PC_READ_OFS;
        e.is_fp = (word[27:24] == FP_CLASS);
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous DEPTH-entry FIFO with flush; head and valid are held in registers
// that are loaded with the post-update head each cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output logic [2:0]   count,
    output logic         valid,
    output fetch_entry_t head
);

    localparam int         PW      = $clog2(DEPTH);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    fetch_entry_t  mem_r [DEPTH];
    fetch_entry_t  head_r;
    fetch_entry_t  head_nxt_s;
    logic [PW-1:0] rd_r;
    logic [PW-1:0] wr_r;
    logic [PW-1:0] rd_nxt_s;
    logic [PW-1:0] wr_nxt_s;
    logic [2:0]    count_r;
    logic [2:0]    count_nxt_s;
    logic          valid_r;
    logic          do_pop_s;
    logic          do_push_s;

    // Next-state pointers, occupancy and head; a push landing in the slot that becomes head bypasses storage.
    always_comb begin
        do_pop_s    = pop && (count_r != 3'd0);
        do_push_s   = push && ((count_r != DEPTH_C) || do_pop_s);
        rd_nxt_s    = do_pop_s  ? rd_r + PW'(1) : rd_r;
        wr_nxt_s    = do_push_s ? wr_r + PW'(1) : wr_r;
        count_nxt_s = count_r + {2'b00, do_push_s} - {2'b00, do_pop_s};
        if (count_nxt_s == 3'd0) begin
            head_nxt_s = head_r;
        end else if (do_push_s && (rd_nxt_s == wr_r)) begin
            head_nxt_s = din;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Storage, pointers and registered head; flush keeps the stale head but drops valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_r    <= '0;
            wr_r    <= '0;
            count_r <= 3'd0;
            valid_r <= 1'b0;
            head_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            rd_r    <= '0;
            wr_r    <= '0;
            count_r <= 3'd0;
            valid_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_r] <= din;
            end
            rd_r    <= rd_nxt_s;
            wr_r    <= wr_nxt_s;
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != 3'd0);
            head_r  <= head_nxt_s;
        end
    end

    assign count = count_r;
    assign valid = valid_r;
    assign head  = head_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing and redirect, predecode, and a small
// output queue towards decode with a valid/ready handshake.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc8,
    output logic        instr_is_fp
);

    logic [31:0]  pc_r;
    logic [2:0]   count_s;
    logic         qvalid_s;
    logic         pop_s;
    logic         fetch_s;
    fetch_entry_t din_s;
    fetch_entry_t head_s;

    // A redirect kills both the pop and the fetch of its cycle.
    always_comb begin
        pop_s   = qvalid_s & instr_ready & ~redirect;
        fetch_s = ~redirect & ((count_s < 3'(DEPTH)) | pop_s);
        din_s   = make_entry(imem_rd, pc_r);
    end

    // Program counter: reset, then redirect, then sequential advance on fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else if (redirect) begin
            pc_r <= {redirect_pc[31:2], 2'b00};
        end else if (fetch_s) begin
            pc_r <= pc_r + PC_STEP;
        end else begin
            pc_r <= pc_r;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk  (clk),
        .reset(reset),
        .flush(redirect),
        .push (fetch_s),
        .pop  (pop_s),
        .din  (din_s),
        .count(count_s),
        .valid(qvalid_s),
        .head (head_s)
    );

    assign imem_a      = pc_r;
    assign instr_valid = qvalid_s;
    assign instr       = head_s.word;
    assign instr_pc    = head_s.pc;
    assign instr_pc8   = head_s.pc8;
    assign instr_is_fp = head_s.is_fp;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc8;
    logic        instr_is_fp;

    int total = 0;
    int bad = 0;

    // Reference model state: the pcs currently buffered, and the next fetch pc.
    logic [31:0] mq[$];
    logic [31:0] mpc;

    typedef struct {
        logic        rst;
        logic        red;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ea;
    } vec_t;
    vec_t tbl[$];

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_a     (imem_a),
        .imem_rd    (imem_rd),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_pc8  (instr_pc8),
        .instr_is_fp(instr_is_fp)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [29:0] i;
        i = a[31:2];
        case (i)
            30'd0:   return 32'hE04F000F;
            30'd1:   return 32'hE2802005;
            30'd2:   return 32'hE3A01001;
            30'd3:   return 32'hE1A02003;
            30'd4:   return 32'hED9F0B04;
            30'd5:   return 32'hE0813002;
            30'd6:   return 32'hE5949008;
            30'd7:   return 32'hEC013002;
            30'd8:   return 32'hEC214002;
            default: return ({i, 2'b00} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
        endcase
    endfunction

    assign imem_rd = mem_word(imem_a);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic red, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic [31:0] ea);
        vec_t v;
        v.rst = rst; v.red = red; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.ea = ea;
        tbl.push_back(v);
    endtask

    // One clock: drive inputs, advance the model by the handshake rules, compare after the edge.
    task automatic step(input logic rst, input logic red, input logic [31:0] rpc, input logic rdy);
        bit p;
        bit f;
        logic [31:0] w;
        reset = rst; redirect = red; redirect_pc = rpc; instr_ready = rdy;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mpc = RESET_PC;
        end else if (red) begin
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            p = (mq.size() > 0) && rdy;
            f = (mq.size() < DEPTH) || p;
            if (p) void'(mq.pop_front());
            if (f) begin
                mq.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
        #1;
        chk("imem_a", imem_a, mpc);
        chk("valid", {31'd0, instr_valid}, {31'd0, mq.size() > 0});
        if (rst) begin
            chk("rst_instr", instr, 32'h0);
            chk("rst_pc", instr_pc, 32'h0);
            chk("rst_pc8", instr_pc8, 32'h0);
            chk("rst_fp", {31'd0, instr_is_fp}, 32'h0);
        end
        if (mq.size() > 0) begin
            w = mem_word(mq[0]);
            chk("head_pc", instr_pc, mq[0]);
            chk("head_word", instr, w);
            chk("head_pc8", instr_pc8, mq[0] + 32'd8);
            chk("head_fp", {31'd0, instr_is_fp}, {31'd0, w[27:24] == 4'hC});
        end
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] rpc;

        // reset, then streaming with ready held high
        add(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h4);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'h8);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'hC);
        // ready low for five cycles: queue saturates, imem_a freezes at 0x8
        add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        add(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h4);
        add(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h8);
        add(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h8);
        add(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h8);
        add(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h8);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'hC);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'h10);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 32'h14);
        // redirect to 0x1E while head 0x4 is offered
        add(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h4);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'h8);
        add(1'b0, 1'b1, 32'h1E, 1'b1, 1'b0, 32'h0, 32'h1C);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1C, 32'h20);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h24);
        // wrap at the top of the address space
        add(1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFC);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFC, 32'h0);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h4);
        // stream 0x18..0x20 for the FP predecode
        add(1'b0, 1'b1, 32'h18, 1'b1, 1'b0, 32'h0, 32'h18);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h18, 32'h1C);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1C, 32'h20);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h24);
        // back-to-back redirects: the last one wins
        add(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 32'h40);
        add(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 32'h100);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h104);
        // fill the queue, then reset it
        add(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h108);
        add(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h108);
        add(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].rst, tbl[k].red, tbl[k].rpc, tbl[k].rdy);
            chk("tbl_valid", {31'd0, instr_valid}, {31'd0, tbl[k].ev});
            chk("tbl_imem_a", imem_a, tbl[k].ea);
            if (tbl[k].ev) begin
                chk("tbl_pc", instr_pc, tbl[k].epc);
                chk("tbl_pc8", instr_pc8, tbl[k].epc + 32'd8);
            end
        end

        // Full queue with simultaneous pop and fetch: occupancy stays at DEPTH.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        prev = instr_pc;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            chk("full_valid", {31'd0, instr_valid}, 32'd1);
            chk("full_seq", instr_pc, prev + 32'd4);
            chk("full_depth", imem_a, instr_pc + 32'd4 * DEPTH);
            prev = instr_pc;
        end

        // Randomized traffic against the reference model.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 600; k++) begin
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF)) : ($urandom & 32'h3FF);
            step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, rpc, $urandom_range(0, 9) < 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
